// File: rtl/la_capture_controller_if.sv
// Pass-through register bus seen by the logic-analyzer capture controller:
// upstream request/response (_i) and the registered downstream copy (_o).
interface la_capture_controller_if;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;

  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic [15:0] rdata_o;
  logic        rw_o;
  logic        valid_o;

  modport master (
    output addr_i, wdata_i, rdata_i, rw_i, valid_i,
    input  addr_o, wdata_o, rdata_o, rw_o, valid_o
  );

  modport slave (
    input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
    output addr_o, wdata_o, rdata_o, rw_o, valid_o
  );
endinterface

// File: rtl/la_capture_controller.sv
// Logic-analyzer capture controller: bus-mapped control registers plus the
// sample-memory write sequencer (pre-trigger fill, free-run, post-trigger).
module la_capture_controller #(
  parameter int BASE_ADDR    = 0,
  parameter int SAMPLE_DEPTH = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            trig,
  la_capture_controller_if.slave          bus,
  output logic                            write_enable_o,
  output logic [$clog2(SAMPLE_DEPTH)-1:0] write_pointer_o
);

  localparam int          AW    = $clog2(SAMPLE_DEPTH);
  localparam int          PW    = AW + 1;
  localparam logic [15:0] BASE  = 16'(BASE_ADDR);
  localparam logic [31:0] DEPTH = 32'(SAMPLE_DEPTH);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    MOVE_TO_POSITION = 3'd1,
    IN_POSITION      = 3'd2,
    CAPTURING        = 3'd3,
    CAPTURED         = 3'd4
  } state_t;

  state_t          state;
  logic [AW-1:0]   trigger_loc;
  logic [AW-1:0]   current_loc;
  logic [PW-1:0]   post_cnt;

  logic [15:0]     offset;
  logic            in_range;
  logic            rd_hit;
  logic            wr_state;
  logic            wr_tloc;
  logic            start_cmd;
  logic            stop_cmd;
  logic            cfg_state;
  logic [AW-1:0]   tloc_sat;
  logic [PW-1:0]   post_target;
  logic [15:0]     reg_val;

  always_comb begin
    offset      = bus.addr_i - BASE;
    in_range    = offset < 16'd4;
    rd_hit      = bus.valid_i && !bus.rw_i && in_range;
    wr_state    = bus.valid_i && bus.rw_i && in_range && (offset[1:0] == 2'd0);
    wr_tloc     = bus.valid_i && bus.rw_i && in_range && (offset[1:0] == 2'd1);
    cfg_state   = (state == IDLE) || (state == CAPTURED);
    stop_cmd    = wr_state && (bus.wdata_i == 16'd0);
    start_cmd   = wr_state && (bus.wdata_i == 16'd1) && cfg_state;
    tloc_sat    = (32'(bus.wdata_i) >= DEPTH) ? AW'(DEPTH - 32'd1) : AW'(bus.wdata_i);
    post_target = PW'(DEPTH) - PW'(trigger_loc);

    reg_val = '0;
    case (offset[1:0])
      2'd0: reg_val = 16'(state);
      2'd1: reg_val = 16'(trigger_loc);
      2'd2: reg_val = 16'(current_loc);
      2'd3: reg_val = 16'(write_pointer_o);
      default: reg_val = '0;
    endcase
  end

  // Downstream bus: one-cycle copy, register reads substituted on rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.addr_o  <= '0;
      bus.wdata_o <= '0;
      bus.rdata_o <= '0;
      bus.rw_o    <= 1'b0;
      bus.valid_o <= 1'b0;
    end else begin
      bus.addr_o  <= bus.addr_i;
      bus.wdata_o <= bus.wdata_i;
      bus.rdata_o <= rd_hit ? reg_val : bus.rdata_i;
      bus.rw_o    <= bus.rw_i;
      bus.valid_o <= bus.valid_i;
    end
  end

  // STOP outranks everything, including a trigger in the same cycle; the
  // pointer is left where it was so software can see how far capture got.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      trigger_loc     <= '0;
      current_loc     <= '0;
      post_cnt        <= '0;
      write_enable_o  <= 1'b0;
      write_pointer_o <= '0;
    end else if (stop_cmd) begin
      state          <= IDLE;
      write_enable_o <= 1'b0;
    end else if (start_cmd) begin
      write_pointer_o <= '0;
      current_loc     <= '0;
      post_cnt        <= '0;
      write_enable_o  <= 1'b1;
      state           <= (trigger_loc == '0) ? IN_POSITION : MOVE_TO_POSITION;
    end else begin
      if (wr_tloc && cfg_state)
        trigger_loc <= tloc_sat;

      case (state)
        MOVE_TO_POSITION: begin
          write_pointer_o <= write_pointer_o + AW'(1);
          current_loc     <= current_loc + AW'(1);
          if (current_loc + AW'(1) == trigger_loc)
            state <= IN_POSITION;
        end
        IN_POSITION: begin
          write_pointer_o <= write_pointer_o + AW'(1);
          if (trig) begin
            post_cnt <= PW'(1);
            // A maximal pre-trigger leaves room only for the trigger sample.
            if (post_target == PW'(1)) begin
              state          <= CAPTURED;
              write_enable_o <= 1'b0;
            end else begin
              state <= CAPTURING;
            end
          end
        end
        CAPTURING: begin
          write_pointer_o <= write_pointer_o + AW'(1);
          post_cnt        <= post_cnt + PW'(1);
          if (post_cnt + PW'(1) == post_target) begin
            state          <= CAPTURED;
            write_enable_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_capture_controller.sv
// Directed bench for la_capture_controller with SAMPLE_DEPTH=8, BASE_ADDR=0.
module tb_la_capture_controller;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       we;
  logic [2:0] wp;

  la_capture_controller_if bus();

  la_capture_controller #(.BASE_ADDR(0), .SAMPLE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .trig            (trig),
    .bus             (bus.slave),
    .write_enable_o  (we),
    .write_pointer_o (wp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int nw       = 0;

  typedef struct {
    bit          v;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] ri;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tv [14];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's bus inputs, then return at the next negedge.
  task automatic step(bit v, bit w, logic [15:0] a, logic [15:0] d);
    bus.valid_i = v;
    bus.rw_i    = w;
    bus.addr_i  = a;
    bus.wdata_i = d;
    @(negedge clk);
    if (we) nw++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rd(logic [15:0] a, logic [15:0] exp, string name);
    step(1'b1, 1'b0, a, 16'h0);
    chk(name, 32'(bus.rdata_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv = '{
      '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF},
      '{1'b1, 1'b1, 16'h0001, 16'd20,   16'h1234, 16'h1234},
      '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'hAAAA, 16'h0007},
      '{1'b1, 1'b1, 16'h0002, 16'h0005, 16'h1111, 16'h1111},
      '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h2222, 16'h0000},
      '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h3333, 16'h0000},
      '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h5555, 16'h5555},
      '{1'b1, 1'b1, 16'h0000, 16'h0005, 16'h6666, 16'h6666},
      '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h7777, 16'h0000},
      '{1'b1, 1'b1, 16'h0001, 16'h0003, 16'h8888, 16'h8888},
      '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h9999, 16'h0003},
      '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'hABCD, 16'hABCD},
      '{1'b1, 1'b1, 16'h0004, 16'h00FF, 16'h0101, 16'h0101},
      '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0202, 16'h0003}
    };

    // Reset with a live TRIGGER_LOC write and trig present.
    rst = 1'b1; trig = 1'b1;
    bus.rdata_i = 16'hC0DE;
    step(1'b1, 1'b1, 16'h0001, 16'h0005);
    chk("rst valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst addr_o",  32'(bus.addr_o),  32'd0);
    chk("rst wdata_o", 32'(bus.wdata_o), 32'd0);
    chk("rst rdata_o", 32'(bus.rdata_o), 32'd0);
    chk("rst rw_o",    32'(bus.rw_o),    32'd0);
    chk("rst we",      32'(we),          32'd0);
    chk("rst wp",      32'(wp),          32'd0);
    rst = 1'b0; trig = 1'b0;
    idle();
    rd(16'h0000, 16'h0000, "rst STATE");
    rd(16'h0001, 16'h0000, "rst TRIGGER_LOC");

    // Register map and passthrough vectors, all in IDLE.
    for (int i = 0; i < 14; i++) begin
      bus.rdata_i = tv[i].ri;
      step(tv[i].v, tv[i].w, tv[i].a, tv[i].d);
      chk($sformatf("v%0d rdata_o", i), 32'(bus.rdata_o), 32'(tv[i].exp_rd));
      chk($sformatf("v%0d addr_o", i),  32'(bus.addr_o),  32'(tv[i].a));
      chk($sformatf("v%0d wdata_o", i), 32'(bus.wdata_o), 32'(tv[i].d));
      chk($sformatf("v%0d rw_o", i),    32'(bus.rw_o),    32'(tv[i].w));
      chk($sformatf("v%0d valid_o", i), 32'(bus.valid_o), 32'(tv[i].v));
      chk($sformatf("v%0d we", i),      32'(we),          32'd0);
    end
    bus.rdata_i = 16'hC0DE;

    // Normal capture, TRIGGER_LOC=3: 3 MOVE + 5 IN_POSITION + 5 post writes.
    nw = 0;
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    chk("cap start we", 32'(we), 32'd1);
    chk("cap start wp", 32'(wp), 32'd0);
    idle();
    idle();
    rd(16'h0000, 16'h0001, "cap 3rd write in MOVE");
    rd(16'h0000, 16'h0002, "cap IN_POSITION");
    chk("cap wp in position", 32'(wp), 32'd4);
    repeat (4) idle();
    chk("cap wp wrapped", 32'(wp), 32'd0);
    trig = 1'b1;
    idle();
    trig = 1'b0;
    rd(16'h0000, 16'h0003, "cap STATE CAPTURING");
    step(1'b1, 1'b1, 16'h0001, 16'h0002);
    idle();
    chk("cap we before end", 32'(we), 32'd1);
    idle();
    chk("cap end we", 32'(we), 32'd0);
    chk("cap end wp", 32'(wp), 32'd5);
    chk("cap write count", 32'(nw), 32'd13);
    rd(16'h0000, 16'h0004, "cap STATE CAPTURED");
    rd(16'h0001, 16'h0003, "cap TRIGGER_LOC guarded");
    rd(16'h0002, 16'h0003, "cap CURRENT_LOC");
    rd(16'h0003, 16'h0005, "cap WRITE_POINTER reg");

    // Zero pre-trigger with trig held high from the START cycle.
    step(1'b1, 1'b1, 16'h0001, 16'h0000);
    rd(16'h0001, 16'h0000, "zp TRIGGER_LOC");
    nw = 0;
    trig = 1'b1;
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    rd(16'h0000, 16'h0002, "zp IN_POSITION");
    repeat (6) idle();
    chk("zp we last", 32'(we), 32'd1);
    idle();
    trig = 1'b0;
    chk("zp end we", 32'(we), 32'd0);
    chk("zp end wp", 32'(wp), 32'd0);
    chk("zp write count", 32'(nw), 32'd8);
    rd(16'h0000, 16'h0004, "zp STATE CAPTURED");

    // START ignored in IN_POSITION, then STOP after two post-trigger writes.
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    chk("restart ignored wp", 32'(wp), 32'd1);
    rd(16'h0000, 16'h0002, "restart ignored STATE");
    trig = 1'b1;
    idle();
    trig = 1'b0;
    step(1'b1, 1'b1, 16'h0000, 16'h0000);
    chk("stop we", 32'(we), 32'd0);
    chk("stop wp held", 32'(wp), 32'd3);
    rd(16'h0000, 16'h0000, "stop STATE");
    chk("stop wp still held", 32'(wp), 32'd3);

    // Trigger and STOP in the same cycle resolve to IDLE.
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    trig = 1'b1;
    step(1'b1, 1'b1, 16'h0000, 16'h0000);
    trig = 1'b0;
    chk("trig+stop we", 32'(we), 32'd0);
    rd(16'h0000, 16'h0000, "trig+stop STATE");

    // trig ignored while moving to position, then reset mid-capture.
    step(1'b1, 1'b1, 16'h0001, 16'h0002);
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    trig = 1'b1;
    rd(16'h0000, 16'h0001, "move ignores trig 1");
    rd(16'h0000, 16'h0001, "move ignores trig 2");
    rd(16'h0000, 16'h0002, "move reaches position");
    trig = 1'b0;
    rd(16'h0000, 16'h0003, "capturing before reset");
    rst = 1'b1; trig = 1'b1;
    step(1'b1, 1'b1, 16'h0000, 16'h0001);
    rst = 1'b0; trig = 1'b0;
    chk("rst mid we", 32'(we), 32'd0);
    chk("rst mid wp", 32'(wp), 32'd0);
    chk("rst mid valid_o", 32'(bus.valid_o), 32'd0);
    nw = 0;
    repeat (3) idle();
    chk("rst mid no writes", 32'(nw), 32'd0);
    rd(16'h0000, 16'h0000, "rst mid STATE");
    rd(16'h0001, 16'h0000, "rst mid TRIGGER_LOC");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
